fetch_prefetch_buffer: RTL and testbench

//  Instruction prefetch queue between program memory and the core fetch port.
//  - Streams sequential instructions from a 1-cycle-latency program memory into a tagged circular buffer.
//  - Presents the head entry to the core when its tag matches the core's pc.
//  - Flushes and refetches on any pc discontinuity (jump/branch/reset).

---
 rtl/risky_fetch_pkg.sv | 33 +++
 rtl/fetch_prefetch_buffer_queue.sv | 54 +++++
 rtl/fetch_prefetch_buffer.sv | 128 ++++++++++++
 tb/tb_fetch_prefetch_buffer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/risky_fetch_pkg.sv
// Shared sizes, types and FSM encoding for the instruction prefetch buffer.
// ADDRESS_SIZE, INSTRUCTION_SIZE and NOP fall back to the architecture.vh values when not already defined.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 16
`endif
`ifndef NOP
`define NOP 16'hFFFF
`endif

package risky_fetch_pkg;

   localparam int ADDR_W      = `ADDRESS_SIZE;
   localparam int INSTR_W     = `INSTRUCTION_SIZE;
   localparam int FETCH_DEPTH = 4;
   localparam int PTR_W       = $clog2(FETCH_DEPTH);

   localparam logic [INSTR_W-1:0] NOP_INSTR = `NOP;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  tag;
      logic [INSTR_W-1:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_buffer_queue.sv
// Tagged circular buffer behind the prefetch FSM: push at tail, pop at head, synchronous clear.
// Clear has priority over push and pop so a flush never keeps a late return.
module fetch_queue
   import risky_fetch_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  fetch_entry_t           push_entry_i,
   output logic [$clog2(DEPTH):0] count_o,
   output fetch_entry_t           head_o
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t  entries_q [DEPTH];
   logic [PW-1:0] head_q;
   logic [PW-1:0] tail_q;
   logic [PW:0]   count_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) tail_q <= tail_q + PW'(1);
         if (pop_i)  head_q <= head_q + PW'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + (PW+1)'(1);
            2'b01:   count_q <= count_q - (PW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is never reset; count_q alone decides which entries are meaningful.
   always_ff @(posedge clock) begin
      if (push_i && !clear_i) entries_q[tail_q] <= push_entry_i;
   end

   assign count_o = count_q;
   assign head_o  = entries_q[head_q];

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch queue: streams sequential reads from program memory and flushes on pc discontinuity.
// Define PREFETCH_STATS_EN to add the hit_count / miss_count statistics outputs.
module fetch_prefetch_buffer
   import risky_fetch_pkg::*;
#(
   parameter int                DEPTH         = FETCH_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_ADDRESS = '0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc,
   input  logic               next,
   output logic [INSTR_W-1:0] instruction,
   output logic               instruction_valid,
   output logic               mem_read,
   output logic [ADDR_W-1:0]  mem_address,
   input  logic [INSTR_W-1:0] mem_data
`ifdef PREFETCH_STATS_EN
   ,
   output logic [31:0]        hit_count,
   output logic [31:0]        miss_count
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t      state_q;
   logic [ADDR_W-1:0] fetch_addr_q;
   logic [ADDR_W-1:0] flush_pc_q;
   logic [ADDR_W-1:0] inflight_addr_q;
   logic              inflight_q;
   logic              squash_q;

   logic [CW-1:0]     count;
   fetch_entry_t      head;
   fetch_entry_t      push_entry;
   logic [ADDR_W-1:0] expected;
   logic              room;
   logic              mismatch;
   logic              issue;
   logic              push;
   logic              pop;

   // The address the core should be asking for next: oldest buffered, else oldest requested, else next to request.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      expected = fetch_addr_q;
      if (inflight_q)    expected = inflight_addr_q;
      if (count != '0)   expected = head.tag;
   end

   assign room     = (count + CW'(inflight_q)) < CW'(DEPTH);
   assign mismatch = (state_q == RUN) && (expected != pc);
   assign issue    = (state_q == RUN) && room;

   assign mem_read    = issue || (state_q == FLUSH);
   assign mem_address = (state_q == FLUSH) ? flush_pc_q :
                        issue              ? fetch_addr_q : '0;

   assign instruction_valid = (state_q == RUN) && (count != '0) && (head.tag == pc);
   assign instruction       = instruction_valid ? head.data : NOP_INSTR;

   assign pop        = instruction_valid && next;
   assign push       = inflight_q && !squash_q && !mismatch;
   assign push_entry = '{tag: inflight_addr_q, data: mem_data};

   fetch_queue #(
      .DEPTH(DEPTH)
   ) u_queue (
      .clock       (clock),
      .reset       (reset),
      .clear_i     (mismatch),
      .push_i      (push),
      .pop_i       (pop),
      .push_entry_i(push_entry),
      .count_o     (count),
      .head_o      (head)
   );

   // squash_q drops exactly one return: the read that was issued alongside the mismatch.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         fetch_addr_q    <= RESET_ADDRESS;
         flush_pc_q      <= '0;
         inflight_addr_q <= '0;
         inflight_q      <= 1'b0;
         squash_q        <= 1'b0;
      end else begin
         inflight_q      <= mem_read;
         inflight_addr_q <= mem_address;
         squash_q        <= mismatch;
         case (state_q)
            IDLE: state_q <= RUN;
            RUN: begin
               if (mismatch) begin
                  state_q      <= FLUSH;
                  flush_pc_q   <= pc;
                  fetch_addr_q <= pc + ADDR_W'(1);
               end else if (room) begin
                  fetch_addr_q <= fetch_addr_q + ADDR_W'(1);
               end
            end
            FLUSH:   state_q <= RUN;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef PREFETCH_STATS_EN
   logic [31:0] hit_q;
   logic [31:0] miss_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if (pop)      hit_q  <= hit_q + 32'd1;
         if (mismatch) miss_q <= miss_q + 32'd1;
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer: streaming, full stall, jump, address wrap, async reset, stats.
// Memory returns {8'h00, addr} one cycle after each read; inputs change 2 time units after the rising edge.
module tb_fetch_prefetch_buffer;
   import risky_fetch_pkg::*;

   logic               clock = 1'b0;
   logic               reset;
   logic [ADDR_W-1:0]  pc, pc_w;
   logic               next, next_w;
   logic [INSTR_W-1:0] instruction, instruction_w;
   logic               instruction_valid, instruction_valid_w;
   logic               mem_read, mem_read_w;
   logic [ADDR_W-1:0]  mem_address, mem_address_w;
   logic [INSTR_W-1:0] mem_data   = '0;
   logic [INSTR_W-1:0] mem_data_w = '0;
`ifdef PREFETCH_STATS_EN
   logic [31:0]        hit_count, miss_count, hit_count_w, miss_count_w;
`endif

   int                 total = 0;
   int                 bad   = 0;
   int                 reads;
   logic [ADDR_W-1:0]  exp_pc;

   always #5 clock = ~clock;

   fetch_prefetch_buffer #(.DEPTH(4), .RESET_ADDRESS('0)) dut (
      .clock            (clock),
      .reset            (reset),
      .pc               (pc),
      .next             (next),
      .instruction      (instruction),
      .instruction_valid(instruction_valid),
      .mem_read         (mem_read),
      .mem_address      (mem_address),
      .mem_data         (mem_data)
`ifdef PREFETCH_STATS_EN
      ,
      .hit_count        (hit_count),
      .miss_count       (miss_count)
`endif
   );

   fetch_prefetch_buffer #(.DEPTH(4), .RESET_ADDRESS('1)) dut_w (
      .clock            (clock),
      .reset            (reset),
      .pc               (pc_w),
      .next             (next_w),
      .instruction      (instruction_w),
      .instruction_valid(instruction_valid_w),
      .mem_read         (mem_read_w),
      .mem_address      (mem_address_w),
      .mem_data         (mem_data_w)
`ifdef PREFETCH_STATS_EN
      ,
      .hit_count        (hit_count_w),
      .miss_count       (miss_count_w)
`endif
   );

   always @(posedge clock) begin
      if (mem_read)   mem_data   <= INSTR_W'(mem_address);
      if (mem_read_w) mem_data_w <= INSTR_W'(mem_address_w);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // Leaves the bench in the IDLE cycle, 2 time units after the edge.
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #2;
      check("rst_vld",   32'(instruction_valid),   32'd0);
      check("rst_rd",    32'(mem_read),            32'd0);
      check("rst_addr",  32'(mem_address),         32'd0);
      check("rst_ins",   32'(instruction),         32'(NOP_INSTR));
      check("rst_rd_w",  32'(mem_read_w),          32'd0);
`ifdef PREFETCH_STATS_EN
      check("rst_hit",   hit_count,                32'd0);
      check("rst_miss",  miss_count,               32'd0);
`endif
      @(posedge clock);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      pc = '0; next = 1'b1; pc_w = '1; next_w = 1'b1;

      // Sequential stream: first read in the first RUN cycle, valid two cycles later.
      do_reset();
      #1 check("idle_rd", 32'(mem_read), 32'd0);
      tick(); #1;
      check("c1_rd",   32'(mem_read),          32'd1);
      check("c1_addr", 32'(mem_address),       32'd0);
      check("c1_vld",  32'(instruction_valid), 32'd0);
      tick(); #1;
      check("c2_addr", 32'(mem_address),       32'd1);
      check("c2_vld",  32'(instruction_valid), 32'd0);
      exp_pc = '0;
      for (int i = 0; i < 6; i++) begin
         tick(); pc = exp_pc; #1;
         check("seq_vld", 32'(instruction_valid), 32'd1);
         check("seq_ins", 32'(instruction),       32'(exp_pc));
         exp_pc++;
      end

      // Jump to 0x40 while streaming: FLUSH reads 0x40, valid two edges after the mismatch edge.
      tick(); pc = 8'h40; #1;
      check("jmp_k_vld",  32'(instruction_valid), 32'd0);
      tick(); #1;
      check("jmp_f_rd",   32'(mem_read),          32'd1);
      check("jmp_f_addr", 32'(mem_address),       32'h40);
      check("jmp_f_vld",  32'(instruction_valid), 32'd0);
      tick(); #1;
      check("jmp_r_vld",  32'(instruction_valid), 32'd0);
      check("jmp_r_addr", 32'(mem_address),       32'h41);
      tick(); #1;
      check("jmp_vld",    32'(instruction_valid), 32'd1);
      check("jmp_ins",    32'(instruction),       32'h40);
      for (int i = 1; i < 3; i++) begin
         tick(); pc = ADDR_W'(8'h40 + i); #1;
         check("jmp_seq_vld", 32'(instruction_valid), 32'd1);
         check("jmp_seq_ins", 32'(instruction),       32'(8'h40 + i));
      end

      // Async reset mid-cycle with a read in flight and a return pending.
      tick(); pc = 8'h43; #1;
      check("ar_pre_rd", 32'(mem_read), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("ar_rd",   32'(mem_read),          32'd0);
      check("ar_addr", 32'(mem_address),       32'd0);
      check("ar_vld",  32'(instruction_valid), 32'd0);
      check("ar_ins",  32'(instruction),       32'(NOP_INSTR));
      pc = '0;
      @(posedge clock); #2 reset = 1'b0;
      #1 check("ar_c0_vld", 32'(instruction_valid), 32'd0);
      tick(); #1;
      check("ar_c1_addr", 32'(mem_address),       32'd0);
      check("ar_c1_vld",  32'(instruction_valid), 32'd0);
      tick(); #1 check("ar_c2_vld", 32'(instruction_valid), 32'd0);
      tick(); #1;
      check("ar_c3_vld", 32'(instruction_valid), 32'd1);
      check("ar_c3_ins", 32'(instruction),       32'd0);

      // Full stall: pc=0 and nothing consumed, so exactly DEPTH reads of addresses 0..DEPTH-1.
      pc = '0; next = 1'b0;
      do_reset();
      reads = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (mem_read) begin
            check("stall_addr", 32'(mem_address), 32'(reads));
            reads++;
         end
         tick();
      end
      #1;
      check("stall_reads", 32'(reads),             32'(1 << PTR_W));
      check("stall_rd",    32'(mem_read),          32'd0);
      check("stall_vld",   32'(instruction_valid), 32'd1);
      check("stall_ins",   32'(instruction),       32'h0000);

      // Wrap: fetch starts at the all-ones address and rolls over to zero.
      pc_w = '1; next_w = 1'b1;
      do_reset();
      tick(); #1;
      check("wrap_c1_rd",   32'(mem_read_w),    32'd1);
      check("wrap_c1_addr", 32'(mem_address_w), 32'hFF);
      tick(); #1 check("wrap_c2_addr", 32'(mem_address_w), 32'h00);
      exp_pc = '1;
      for (int i = 0; i < 10; i++) begin
         tick(); pc_w = exp_pc; #1;
         check("wrap_vld", 32'(instruction_valid_w), 32'd1);
         check("wrap_ins", 32'(instruction_w),       32'(exp_pc));
         exp_pc++;
      end

`ifdef PREFETCH_STATS_EN
      // Eight pops, then two jumps while nothing is consumed.
      pc = '0; next = 1'b1;
      do_reset();
      tick(); tick();
      exp_pc = '0;
      for (int i = 0; i < 8; i++) begin
         tick(); pc = exp_pc; #1;
         check("st_vld", 32'(instruction_valid), 32'd1);
         exp_pc++;
      end
      tick(); next = 1'b0; pc = 8'h20;
      for (int i = 0; i < 4; i++) tick();
      pc = 8'h30;
      for (int i = 0; i < 4; i++) tick();
      #1;
      check("st_hit",  hit_count,  32'd8);
      check("st_miss", miss_count, 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
